// File: rtl/program_loader_pkg.sv
// Shared constants for the program loader: widths, frame marker, FSM state codes
// and the checksum step used while a frame streams in.
package program_loader_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  localparam logic [DATA_W-1:0] SYNC_BYTE = 8'hA5;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LEN   = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_CSUM  = 3'd3;
  localparam logic [2:0] ST_CHECK = 3'd4;
  localparam logic [2:0] ST_RUN   = 3'd5;

  function automatic logic [DATA_W-1:0] csum_step(input logic [DATA_W-1:0] acc,
                                                  input logic [DATA_W-1:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/program_loader_ram.sv
// 8x8 program memory: synchronous write, asynchronous read, cleared by rst_n.
module program_ram
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Storage array with whole-array clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/program_loader.sv
// Framed-byte program loader: parses SYNC/LEN/DATA/CSUM frames into program_ram,
// serves the fetch port and releases the processor once a frame verifies.
module program_loader
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] instruction,
  output logic              run,
  output logic              busy,
  output logic              err,
  output logic [3:0]        loaded_len
);

  logic [2:0]        state_r;
  logic [2:0]        state_s;
  logic [3:0]        len_r;
  logic [ADDR_W-1:0] cnt_r;
  logic [DATA_W-1:0] acc_r;
  logic [DATA_W-1:0] csum_r;
  logic              run_r;
  logic              err_r;
  logic [3:0]        loaded_len_r;
  logic              accept_s;
  logic              is_sync_s;
  logic              len_ok_s;
  logic              last_s;
  logic              we_s;

  assign accept_s  = rx_valid && rx_ready;
  assign is_sync_s = (rx_data == SYNC_BYTE);
  assign len_ok_s  = (rx_data >= 8'd1) && (rx_data <= 8'(DEPTH));
  assign last_s    = ({1'b0, cnt_r} == (len_r - 4'd1));
  assign we_s      = accept_s && (state_r == ST_DATA);

  // Frame parser next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && is_sync_s) state_s = ST_LEN;
        else                       state_s = ST_IDLE;
      end
      ST_LEN: begin
        if (accept_s) state_s = len_ok_s ? ST_DATA : ST_IDLE;
        else          state_s = ST_LEN;
      end
      ST_DATA: begin
        if (accept_s && last_s) state_s = ST_CSUM;
        else                    state_s = ST_DATA;
      end
      ST_CSUM: begin
        if (accept_s) state_s = ST_CHECK;
        else          state_s = ST_CSUM;
      end
      ST_CHECK: begin
        if (csum_r == acc_r) state_s = ST_RUN;
        else                 state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (accept_s && is_sync_s) state_s = ST_LEN;
        else                       state_s = ST_RUN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, length/counter/checksum bookkeeping and the status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      len_r        <= 4'd0;
      cnt_r        <= '0;
      acc_r        <= '0;
      csum_r       <= '0;
      run_r        <= 1'b0;
      err_r        <= 1'b0;
      loaded_len_r <= 4'd0;
    end else begin
      state_r <= state_s;
      // run follows the state we are entering, so it drops right after a restart SYNC
      run_r   <= (state_s == ST_RUN);
      case (state_r)
        ST_LEN: begin
          if (accept_s && len_ok_s) begin
            len_r <= rx_data[3:0];
            cnt_r <= '0;
            acc_r <= '0;
          end else if (accept_s) begin
            err_r <= 1'b1;
          end
        end
        ST_DATA: begin
          if (accept_s) begin
            acc_r <= csum_step(acc_r, rx_data);
            cnt_r <= cnt_r + 3'd1;
          end
        end
        ST_CSUM: begin
          if (accept_s) csum_r <= rx_data;
        end
        ST_CHECK: begin
          if (csum_r == acc_r) begin
            loaded_len_r <= len_r;
            err_r        <= 1'b0;
          end else begin
            err_r <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  program_ram u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_s),
    .waddr (cnt_r),
    .wdata (rx_data),
    .raddr (address),
    .rdata (instruction)
  );

  assign rx_ready   = (state_r != ST_CHECK);
  assign busy       = (state_r == ST_LEN) || (state_r == ST_DATA) ||
                      (state_r == ST_CSUM) || (state_r == ST_CHECK);
  assign run        = run_r;
  assign err        = err_r;
  assign loaded_len = loaded_len_r;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Writer-side counterpart of the instruction fetch path: receives a framed byte stream from a host link and writes it into an 8-entry program memory. Serves the processor's fetch port with the same address-in/instruction-out interface as the program ROM, so it drops in where the ROM sits. Holds the processor in reset (run=0) until a frame has loaded and its checksum has verified.

Parameters:
DATA_W, 8, instruction/byte width
ADDR_W, 3, fetch address width
DEPTH, 8, program memory entries (2**ADDR_W)
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
rx_data  input  DATA_W  incoming byte from host link
rx_valid  input  1  rx_data valid this cycle
rx_ready  output  1  loader accepts byte; transfer occurs when rx_valid && rx_ready at posedge
address  input  ADDR_W  processor fetch address
instruction  output  DATA_W  program memory word at address (combinational read)
run  output  1  processor enable; 0 holds processor in reset
busy  output  1  frame in progress (states LEN, DATA, CSUM, CHECK)
err  output  1  last frame rejected; sticky
loaded_len  output  4  entry count of last good frame (0..8)

Behaviour:
- Reset (async, rst_n=0): state IDLE; memory cleared to 8'h00; run=0, busy=0, err=0, loaded_len=0, rx_ready=1 on release; byte counter=0; checksum accumulator=0.
- Frame format: SYNC_BYTE, LEN (1..8), LEN instruction bytes, CSUM = XOR of the instruction bytes.
- States: IDLE, LEN, DATA, CSUM, CHECK, RUN.
- IDLE: accepted byte == SYNC_BYTE -> LEN. Any other byte is consumed and discarded.
- LEN: if accepted byte is in 1..DEPTH, latch the length, clear counter and accumulator, go to DATA. A value of 0 or >DEPTH sets err=1 and goes to IDLE.
- DATA: each accepted byte writes mem[counter] on that edge, accumulator ^= byte, counter++. On the byte where counter==len-1, go to CSUM.
- CSUM: the accepted byte is latched and the state goes to CHECK.
- CHECK: lasts one cycle with rx_ready=0. If the latched byte equals the accumulator: loaded_len=len, err=0, next state RUN. Otherwise err=1 and next state IDLE.
- run is registered: it rises on the first cycle in RUN, i.e. 2 cycles after the CSUM byte handshake.
- RUN: run=1. An accepted SYNC_BYTE restarts a load: run=0 on the next cycle, state goes to LEN. Other bytes are discarded.
- Entries at or above len keep their prior contents and are not cleared between frames.
- Memory writes occur only in DATA. instruction reflects the new value combinationally from the cycle after the write.
- rx_ready=1 in every state except CHECK.
- err clears only on a successful CHECK or on reset. A new SYNC_BYTE in IDLE does not clear it.
- busy=1 in LEN, DATA, CSUM and CHECK.
- rx_valid without rx_ready has no effect. rx_data is ignored when rx_valid=0.
- Reset asserted mid-frame: immediate return to reset values, including memory clear, with no partial run.

Decomposition:
- Shared package: state enum (IDLE, LEN, DATA, CSUM, CHECK, RUN), SYNC_BYTE, DATA_W, ADDR_W, DEPTH constants.
- One natural sub-module: program_ram, an 8x8 memory with synchronous write, asynchronous read and an async clear on rst_n. The FSM, counter and checksum logic stay in program_loader.

Test Plan:
- Good frame A5,03,11,22,44,77 -> mem[0..2]=11,22,44; mem[3..7]=00; loaded_len=3; err=0; run=1 exactly 2 cycles after the 77 handshake; address=1 gives instruction=22.
- Bad checksum A5,02,0F,F0,00 -> err=1, run=0, state IDLE, loaded_len unchanged (0), mem[0..1]=0F,F0.
- Bad length A5,00 and, separately, A5,09 -> err=1 right after the LEN byte; following bytes 01,02 discarded; mem unchanged.
- Reload: first a good 8-byte frame, then A5,01,AA,AA -> run drops the cycle after A5 and returns to 1 after CHECK; mem[0]=AA; mem[1..7] keep the old values; loaded_len=1.
- Handshake: rx_valid toggled pseudo-randomly during a frame -> same final memory as back-to-back delivery; rx_ready=0 exactly one cycle (CHECK); a byte presented in that cycle is not consumed.
- Reset mid-DATA (after 2 of 4 bytes): outputs go to reset values asynchronously, memory all 00; a subsequent good frame loads correctly.
